// File: rtl/esm_sched_pkg.sv
// Shared types and sizing constants for the ESM issue scheduler.
package esm_sched_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WAITING = 2'd1,
    ISSUED  = 2'd2
  } slot_state_t;

  localparam int DEFAULT_BS    = 16;
  localparam int DEFAULT_IDX_W = $clog2(DEFAULT_BS);

endpackage

// File: rtl/esm_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module esm_rr_pick
  import esm_sched_pkg::*;
#(
  parameter int BS = DEFAULT_BS,
  parameter int IW = DEFAULT_IDX_W
) (
  input  logic [BS-1:0] req,
  input  logic [IW-1:0] start,
  output logic          grant_valid,
  output logic [IW-1:0] grant_index
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest request to start wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    idx         = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      idx = start + IW'(i);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_index = idx;
      end
    end
  end

endmodule

// File: rtl/esm_issue_scheduler.sv
// Slot allocator and round-robin issue stage for the ESM instruction buffer.
// Optional ESM_SCHED_PERF_EN adds perf_issued / perf_stall counters.
module esm_issue_scheduler
  import esm_sched_pkg::*;
#(
  parameter int bs                    = DEFAULT_BS,
  parameter int Instruction_word_size = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [Instruction_word_size-1:0] in_instr,
  output logic                             alloc_en,
  output logic [$clog2(bs)-1:0]            alloc_index,
  output logic [0:bs-1]                    valid_entries,
  input  logic [0:bs-1]                    independent_instr,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [$clog2(bs)-1:0]            issue_index,
  output logic [Instruction_word_size-1:0] issue_instr,
  input  logic                             retire_valid,
  input  logic [$clog2(bs)-1:0]            retire_index,
  output logic [$clog2(bs):0]              count,
`ifdef ESM_SCHED_PERF_EN
  output logic [31:0]                      perf_issued,
  output logic [31:0]                      perf_stall,
`endif
  output logic                             err_retire
);

  localparam int IW = $clog2(bs);

  slot_state_t                      slot_state [bs];
  logic [Instruction_word_size-1:0] slot_instr [bs];

  logic [bs-1:0] free_vec;
  logic [bs-1:0] eligible;
  logic [IW-1:0] last_issued;
  logic [IW-1:0] pick_start;
  logic          grant_valid;
  logic [IW-1:0] grant_index;
  logic          issue_fire;
  logic          issue_load;
  logic          retire_ok;

  always_comb begin
    free_vec      = '0;
    eligible      = '0;
    valid_entries = '0;
    for (int i = 0; i < bs; i++) begin
      free_vec[i]      = (slot_state[i] == FREE);
      eligible[i]      = (slot_state[i] == WAITING) & independent_instr[i];
      valid_entries[i] = (slot_state[i] != FREE);
    end
  end

  // No handshake is offered in a reset cycle, so in_ready is held low under rst.
  always_comb begin
    in_ready    = (|free_vec) & ~rst;
    alloc_index = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_index = IW'(i);
    end
  end

  assign alloc_en   = in_valid & in_ready;
  assign issue_fire = issue_valid & issue_ready;
  assign issue_load = (~issue_valid | issue_ready) & grant_valid;
  assign retire_ok  = retire_valid & (slot_state[retire_index] == ISSUED);
  assign pick_start = last_issued + 1'b1;

  esm_rr_pick #(
    .BS(bs),
    .IW(IW)
  ) u_pick (
    .req        (eligible),
    .start      (pick_start),
    .grant_valid(grant_valid),
    .grant_index(grant_index)
  );

  // Alloc, issue and retire always target slots in different states, so never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) slot_state[i] <= FREE;
      issue_valid <= 1'b0;
      issue_index <= '0;
      issue_instr <= '0;
      last_issued <= IW'(bs - 1);
      count       <= '0;
      err_retire  <= 1'b0;
    end else begin
      if (alloc_en) slot_state[alloc_index] <= WAITING;

      if (issue_load) begin
        slot_state[grant_index] <= ISSUED;
        issue_valid             <= 1'b1;
        issue_index             <= grant_index;
        issue_instr             <= slot_instr[grant_index];
        last_issued             <= grant_index;
      end else if (issue_fire) begin
        issue_valid <= 1'b0;
      end

      if (retire_valid) begin
        if (retire_ok) slot_state[retire_index] <= FREE;
        else           err_retire               <= 1'b1;
      end

      case ({alloc_en, retire_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en) slot_instr[alloc_index] <= in_instr;
  end

`ifdef ESM_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (issue_fire)          perf_issued <= perf_issued + 32'd1;
      if (in_valid & ~in_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
